// File: rtl/snr_power_accumulator.sv
// Windowed mean signal/noise power (sum of squares >> LOG2_WIN) with a valid/ready result port.
// Optional SNR_NOISE_PEAK_EN adds noise_peak, the largest |noise_in| seen in the window.
module snr_power_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_WIN   = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sample_valid,
  input  logic [DATA_WIDTH-1:0]     signal_in,
  input  logic [DATA_WIDTH-1:0]     noise_in,
  input  logic                      clear,
  output logic [2*DATA_WIDTH-1:0]   sig_power,
  output logic [2*DATA_WIDTH-1:0]   noise_power,
  output logic                      power_valid,
  input  logic                      power_ready,
  output logic                      overrun
`ifdef SNR_NOISE_PEAK_EN
  ,
  output logic [DATA_WIDTH-1:0]     noise_peak
`endif
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = PW + LOG2_WIN;

  // Stage-1 product registers
  typedef struct packed {
    logic [PW-1:0] sq_sig;
    logic [PW-1:0] sq_noise;
    logic          last;
  } s1_t;

  s1_t                  s1;
  logic                 s1_valid;
  logic [LOG2_WIN-1:0]  count;
  logic [AW-1:0]        acc_sig, acc_noise;

  logic signed [DATA_WIDTH-1:0] noise_s;
  logic signed [PW-1:0]         noise_sq_s;
  logic [PW-1:0]                sig_sq;
  logic [AW-1:0]                sum_sig, sum_noise;
  logic                         load;

  assign noise_s    = noise_in;
  assign noise_sq_s = PW'(noise_s) * PW'(noise_s);
  assign sig_sq     = PW'(signal_in) * PW'(signal_in);
  assign sum_sig    = acc_sig + AW'(s1.sq_sig);
  assign sum_noise  = acc_noise + AW'(s1.sq_noise);
  // clear squashes the in-flight last sample, so its result never loads
  assign load       = s1_valid && s1.last && !clear;

`ifdef SNR_NOISE_PEAK_EN
  logic [DATA_WIDTH-1:0] s1_abs, peak_run, abs_in, peak_max;
  // Two's-complement negate of the most-negative value yields 2^(DW-1) as unsigned
  assign abs_in   = noise_in[DATA_WIDTH-1] ? (~noise_in + DATA_WIDTH'(1)) : noise_in;
  assign peak_max = (s1_abs > peak_run) ? s1_abs : peak_run;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1          <= '0;
      s1_valid    <= 1'b0;
      count       <= '0;
      acc_sig     <= '0;
      acc_noise   <= '0;
      sig_power   <= '0;
      noise_power <= '0;
      power_valid <= 1'b0;
      overrun     <= 1'b0;
`ifdef SNR_NOISE_PEAK_EN
      s1_abs      <= '0;
      peak_run    <= '0;
      noise_peak  <= '0;
`endif
    end else begin
      if (clear) begin
        s1_valid  <= 1'b0;
        count     <= '0;
        acc_sig   <= '0;
        acc_noise <= '0;
`ifdef SNR_NOISE_PEAK_EN
        peak_run  <= '0;
`endif
      end else begin
        s1_valid <= sample_valid;
        if (sample_valid) begin
          s1.sq_sig   <= sig_sq;
          s1.sq_noise <= PW'(unsigned'(noise_sq_s));
          s1.last     <= &count;
          count       <= count + LOG2_WIN'(1);
`ifdef SNR_NOISE_PEAK_EN
          s1_abs      <= abs_in;
`endif
        end
        if (s1_valid) begin
          if (s1.last) begin
            acc_sig   <= '0;
            acc_noise <= '0;
`ifdef SNR_NOISE_PEAK_EN
            peak_run  <= '0;
`endif
          end else begin
            acc_sig   <= sum_sig;
            acc_noise <= sum_noise;
`ifdef SNR_NOISE_PEAK_EN
            peak_run  <= peak_max;
`endif
          end
        end
      end

      if (load) begin
        sig_power   <= sum_sig[AW-1:LOG2_WIN];
        noise_power <= sum_noise[AW-1:LOG2_WIN];
        power_valid <= 1'b1;
`ifdef SNR_NOISE_PEAK_EN
        noise_peak  <= peak_max;
`endif
        if (power_valid && !power_ready)
          overrun <= 1'b1;
      end else if (power_valid && power_ready) begin
        power_valid <= 1'b0;
      end
    end
  end

endmodule
